zsy_bcd_cnt_disp: RTL and testbench
===================================

Name: zsy_bcd_cnt_disp

Overview:
- Parametrised, multi-digit successor to the single-digit counter/compare/7-segment chain.
- Holds a DIGITS-wide BCD up/down counter with synchronous load and a programmable terminal value; reaching the terminal value reloads the preset.
- Drives a time-multiplexed, registered 7-segment display: one shared segment bus plus one-hot digit selects.
- Sits between the board switches/clock and the display header.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- SCAN_W, 4, width of the scan prescaler; each digit is shown for 2^SCAN_W cycles.

Ports:
- CP  in  1  clock, rising edge.
- MRN  in  1  asynchronous active-low reset.
- EN  in  1  count enable.
- UP  in  1  direction: 1 = up, 0 = down.
- LD  in  1  synchronous parallel load.
- Dn  in  4*DIGITS  preset value (BCD, digit 0 in bits [3:0]).
- DataB  in  4*DIGITS  terminal value (BCD).
- Q  out  4*DIGITS  current count.
- TC  out  1  terminal-count pulse, registered.
- Seg  out  8  segments, active-high; bit0 = a … bit6 = g, bit7 = dp.
- Dig  out  DIGITS  one-hot digit select, active-high.

Behaviour:
- Clock and reset: one clock, CP. Reset is asynchronous and active-low on MRN, and is fixed so.
- Reset values (MRN=0, takes effect immediately, including mid-count or mid-scan):
  - Q=0, TC=0, Seg=8'h00, Dig=0.
  - Scan prescaler = 0, scan index = 0.
- Counter update per rising CP edge, in priority order:
  - LD=1: Q<=Dn. TC<=0. EN is ignored.
  - EN=1 and Q==DataB: Q<=Dn; TC<=1 for exactly one cycle. Compare is on the full 4*DIGITS bits; direction is irrelevant.
  - EN=1, UP=1: BCD increment.
    - Digit 9 -> 0 with carry into the next digit.
    - A digit holding A..F is treated as 9 (-> 0, carry).
    - All-9s wraps to all-0s; no TC unless DataB matches.
  - EN=1, UP=0: BCD decrement.
    - Digit 0 -> 9 with borrow.
    - A digit holding A..F -> 9, no borrow.
    - All-0s wraps to all-9s.
  - EN=0: Q holds.
  - TC<=0 in every case not listed above.
- Dn and DataB are not validated; non-BCD values load and compare verbatim.
- Scan:
  - The prescaler increments every cycle.
  - When it wraps from all-ones to 0, the scan index advances 0,1,…,DIGITS-1,0.
  - DIGITS=1: the index stays 0.
- Display registers, updated every cycle:
  - Dig <= one-hot(scan index).
  - Seg <= decode(digit[scan index] of Q).
  - Seg therefore shows Q from the previous cycle (1-cycle latency).
  - First non-zero Dig is 1 on the first edge after reset release.
- Decode, Seg[6:0] per digit value:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66.
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A..F = 00 (blank).
- Seg[7] (dp) = 0 always.
- Simultaneous LD and terminal match: LD wins and TC stays 0.
- Dn==DataB with EN=1: Q reloads the same value every cycle, and TC stays 1 continuously.

Optional Feature:
- Macro: ZSY_BCD_LZB_EN.
- Defined: leading-zero blanking.
  - Digit k (k≥1) shows Seg=00 when digit k and every more-significant digit are 0.
  - Digit 0 is never blanked.
  - Dig timing is unchanged.
- Undefined: every digit is decoded normally, so zeros show 3F.

Test Plan:
- Reset mid-count, DIGITS=2:
  - Count to 8'h37, pulse MRN=0 asynchronously between edges.
  - Q=00, TC=0, Seg=00 and Dig=00 immediately.
  - First edge after release: Dig=01, Seg=3F.
- Up count with carry: LD with Dn=8'h08, then EN=1, UP=1, DataB=8'h99 -> Q=08,09,10,11; at 99 the next edge gives Dn (08) and TC=1 for one cycle.
- Down count with borrow: Dn=8'h10, LD, then UP=0, DataB=8'h55 -> Q=10,09,08; from 00, Q wraps to 99.
- Terminal reload: Dn=8'h03, DataB=8'h05, UP=1 -> Q=03,04,05,03,04; TC high on the cycle Q=03 after each 05; hold EN=0 at Q=04 -> Q and TC stay 04/0.
- LD vs terminal: Q=DataB=8'h05, EN=1, LD=1, Dn=8'h42 -> Q=42, TC=0.
- Scan, SCAN_W=2:
  - Q=8'h27, Dig sequence 01 (4 cycles) then 10 (4 cycles), with Seg=07 then 5B.
  - With ZSY_BCD_LZB_EN and Q=8'h05: digit 1 Seg=00, digit 0 Seg=6D.
  - Without the macro: digit 1 Seg=3F.

Source files
------------

// File: rtl/zsy_bcd_cnt_disp.sv
// rtl/zsy_bcd_cnt_disp.sv - multi-digit BCD up/down counter with terminal reload and multiplexed 7-segment display
// Optional leading-zero blanking: define ZSY_BCD_LZB_EN.
module zsy_bcd_cnt_disp #(
    parameter int DIGITS = 2,
    parameter int SCAN_W = 4
) (
    input  logic                  CP,
    input  logic                  MRN,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   Dn,
    input  logic [4*DIGITS-1:0]   DataB,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Dig
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [W-1:0]       q_inc;
    logic [W-1:0]       q_dec;
    logic [W-1:0]       q_next;
    logic               tc_next;
    logic               carry;
    logic               borrow;
    logic [3:0]         inc_digit;
    logic [3:0]         dec_digit;

    logic [SCAN_W-1:0]  pre;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         cur_digit;
    logic [DIGITS-1:0]  upper_zero;
    logic               zero_acc;
    logic               blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Ripple carry: digits >= 9 (including A..F) roll to 0 and pass the carry on.
    always_comb begin
        q_inc     = Q;
        carry     = 1'b1;
        inc_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            inc_digit = Q[i*4 +: 4];
            if (carry) begin
                if (inc_digit >= 4'd9) begin
                    q_inc[i*4 +: 4] = 4'd0;
                end else begin
                    q_inc[i*4 +: 4] = inc_digit + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    // Ripple borrow: 0 rolls to 9 with borrow, A..F snaps to 9 and absorbs it.
    always_comb begin
        q_dec     = Q;
        borrow    = 1'b1;
        dec_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dec_digit = Q[i*4 +: 4];
            if (borrow) begin
                if (dec_digit == 4'd0) begin
                    q_dec[i*4 +: 4] = 4'd9;
                end else if (dec_digit > 4'd9) begin
                    q_dec[i*4 +: 4] = 4'd9;
                    borrow          = 1'b0;
                end else begin
                    q_dec[i*4 +: 4] = dec_digit - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        q_next  = Q;
        tc_next = 1'b0;
        if (LD) begin
            q_next = Dn;
        end else if (EN) begin
            if (Q == DataB) begin
                q_next  = Dn;
                tc_next = 1'b1;
            end else if (UP) begin
                q_next = q_inc;
            end else begin
                q_next = q_dec;
            end
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Q  <= '0;
            TC <= 1'b0;
        end else begin
            Q  <= q_next;
            TC <= tc_next;
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre + SCAN_W'(1);
            if (pre == {SCAN_W{1'b1}}) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // upper_zero[k] is set when digit k and all more-significant digits are zero.
    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = '0;
        zero_acc   = 1'b1;
        blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & (Q[i*4 +: 4] == 4'd0);
            upper_zero[i] = zero_acc;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = Q[i*4 +: 4];
`ifdef ZSY_BCD_LZB_EN
                if (i != 0) begin
                    blank = upper_zero[i];
                end
`endif
            end
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Seg <= 8'h00;
            Dig <= '0;
        end else begin
            Dig <= DIGITS'(1) << idx;
            Seg <= {1'b0, blank ? 7'h00 : seg7(cur_digit)};
        end
    end

endmodule

// File: tb/tb_zsy_bcd_cnt_disp.sv
// tb/tb_zsy_bcd_cnt_disp.sv - scoreboard bench for zsy_bcd_cnt_disp (DIGITS=2, SCAN_W=2)
module tb_zsy_bcd_cnt_disp;

    localparam int D  = 2;
    localparam int SW = 2;

    logic           CP = 1'b0;
    logic           MRN = 1'b1;
    logic           EN = 1'b0;
    logic           UP = 1'b0;
    logic           LD = 1'b0;
    logic [7:0]     Dn = 8'h00;
    logic [7:0]     DataB = 8'h00;
    logic [7:0]     Q;
    logic           TC;
    logic [7:0]     Seg;
    logic [1:0]     Dig;

    zsy_bcd_cnt_disp #(.DIGITS(D), .SCAN_W(SW)) dut (
        .CP(CP), .MRN(MRN), .EN(EN), .UP(UP), .LD(LD),
        .Dn(Dn), .DataB(DataB), .Q(Q), .TC(TC), .Seg(Seg), .Dig(Dig)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic [7:0] seg;
        logic [1:0] dig;
        int         id;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_steps  = 0;

    logic [7:0] m_q   = 8'h00;
    int         m_cyc = 0;

    logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    task automatic check(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h, expected %h", nm, id, act, exp);
    endtask

    function automatic logic [7:0] m_inc(input logic [7:0] q);
        logic [7:0] r = q;
        for (int j = 0; j < D; j++) begin
            if (r[j*4 +: 4] < 4'd9) begin
                r[j*4 +: 4] = r[j*4 +: 4] + 4'd1;
                return r;
            end
            r[j*4 +: 4] = 4'd0;
        end
        return r;
    endfunction

    function automatic logic [7:0] m_dec(input logic [7:0] q);
        logic [7:0] r = q;
        for (int j = 0; j < D; j++) begin
            if (r[j*4 +: 4] == 4'd0) begin
                r[j*4 +: 4] = 4'd9;
            end else begin
                r[j*4 +: 4] = (r[j*4 +: 4] > 4'd9) ? 4'd9 : r[j*4 +: 4] - 4'd1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] m_seg(input logic [7:0] q, input int k);
        logic [7:0] upper;
        upper = q >> (4 * k);
`ifdef ZSY_BCD_LZB_EN
        if (k > 0 && upper == 8'h00) return 8'h00;
`endif
        return {1'b0, lut[upper[3:0]]};
    endfunction

    // Drive one cycle of inputs; the model result for this edge goes to the scoreboard.
    task automatic step(input logic en_i, input logic up_i, input logic ld_i,
                        input logic [7:0] dn_i, input logic [7:0] db_i);
        exp_t e;
        int   k;
        EN = en_i; UP = up_i; LD = ld_i; Dn = dn_i; DataB = db_i;
        @(posedge CP);
        k     = (m_cyc / (1 << SW)) % D;
        e.seg = m_seg(m_q, k);
        e.dig = 2'(1 << k);
        e.tc  = 1'b0;
        if (ld_i) begin
            m_q = dn_i;
        end else if (en_i && m_q == db_i) begin
            m_q  = dn_i;
            e.tc = 1'b1;
        end else if (en_i) begin
            m_q = up_i ? m_inc(m_q) : m_dec(m_q);
        end
        e.q  = m_q;
        e.id = n_steps;
        n_steps++;
        m_cyc++;
        sbq.push_back(e);
        @(negedge CP);
        #1;
    endtask

    task automatic do_reset();
        MRN = 1'b0;
        #1;
        check("rst_q",   -1, Q, 8'h00);
        check("rst_tc",  -1, {7'b0, TC}, 8'h00);
        check("rst_seg", -1, Seg, 8'h00);
        check("rst_dig", -1, {6'b0, Dig}, 8'h00);
        #1;
        MRN   = 1'b1;
        m_q   = 8'h00;
        m_cyc = 0;
    endtask

    always @(negedge CP) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("q",   e.id, Q, e.q);
            check("tc",  e.id, {7'b0, TC}, {7'b0, e.tc});
            check("seg", e.id, Seg, e.seg);
            check("dig", e.id, {6'b0, Dig}, {6'b0, e.dig});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] dn_r, db_r;
        @(negedge CP);
        #1;
        do_reset();
        step(0, 0, 0, 8'h00, 8'h00);

        step(0, 1, 1, 8'h08, 8'h99);
        repeat (3) step(1, 1, 0, 8'h08, 8'h99);
        step(0, 1, 1, 8'h98, 8'h99);
        repeat (3) step(1, 1, 0, 8'h08, 8'h99);

        step(0, 0, 1, 8'h10, 8'h55);
        repeat (2) step(1, 0, 0, 8'h10, 8'h55);
        step(0, 0, 1, 8'h00, 8'h55);
        repeat (2) step(1, 0, 0, 8'h10, 8'h55);

        step(0, 1, 1, 8'h03, 8'h05);
        repeat (5) step(1, 1, 0, 8'h03, 8'h05);
        repeat (3) step(0, 1, 0, 8'h03, 8'h05);

        step(0, 1, 1, 8'h05, 8'h05);
        step(1, 1, 1, 8'h42, 8'h05);
        step(1, 1, 0, 8'h42, 8'h07);

        step(0, 1, 1, 8'h11, 8'h11);
        repeat (3) step(1, 1, 0, 8'h11, 8'h11);

        step(0, 1, 1, 8'h0C, 8'h99);
        repeat (3) step(1, 1, 0, 8'h00, 8'h99);
        step(0, 0, 1, 8'hA0, 8'h55);
        repeat (2) step(1, 0, 0, 8'h00, 8'h55);

        step(0, 0, 1, 8'h27, 8'h00);
        repeat (12) step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 1, 8'h05, 8'h00);
        repeat (10) step(0, 0, 0, 8'h00, 8'h00);

        step(0, 1, 1, 8'h36, 8'h99);
        step(1, 1, 0, 8'h36, 8'h99);
        do_reset();
        step(0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            dn_r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 9) == 0) dn_r = 8'($urandom);
            db_r = ($urandom_range(0, 3) == 0) ? m_q
                   : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0), dn_r, db_r);
        end

        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge CP);
        #1;
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
